// File: rtl/fifo_ram_sc_pkg.sv
// Shared defaults for the FIFO storage RAM and its bus interface.
package fifo_ram_sc_pkg;

  localparam int unsigned DefAddrWidth = 4;
  localparam int unsigned DefDataWidth = 8;

endpackage

// File: rtl/fifo_ram_sc_if.sv
// Port-A write/read-first and port-B read bus of the FIFO storage RAM.
interface fifo_ram_sc_if
  import fifo_ram_sc_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DefAddrWidth,
  parameter int unsigned DATA_WIDTH = DefDataWidth
);

  logic                  wea;
  logic [ADDR_WIDTH-1:0] addra;
  logic [DATA_WIDTH-1:0] dia;
  logic [DATA_WIDTH-1:0] doa;
  logic [ADDR_WIDTH-1:0] addrb;
  logic [DATA_WIDTH-1:0] dob;

  modport master (
    output wea, addra, dia, addrb,
    input  doa, dob
  );

  modport slave (
    input  wea, addra, dia, addrb,
    output doa, dob
  );

endinterface

// File: rtl/fifo_ram_sc.sv
// Single-clock simple dual-port RAM: port A writes with read-first output, port B reads.
// Both outputs are registered; the array itself is never reset so it maps onto block RAM.
module fifo_ram_sc
  import fifo_ram_sc_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DefAddrWidth,
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter bit          BYPASS     = 1'b0
) (
  input logic         clk,
  input logic         resetb,
  fifo_ram_sc_if.slave bus
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [Depth];
  logic [DATA_WIDTH-1:0] doa_q;
  logic [DATA_WIDTH-1:0] dob_q;
  logic [DATA_WIDTH-1:0] dob_d;
  logic                  collide;

  assign collide = bus.wea && (bus.addra == bus.addrb);

  always_comb begin
    dob_d = mem[bus.addrb];
    if (BYPASS && collide) begin
      dob_d = bus.dia;
    end
  end

  // Writes are suppressed while reset is asserted; contents survive reset.
  always_ff @(posedge clk) begin
    if (resetb && bus.wea) begin
      mem[bus.addra] <= bus.dia;
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      doa_q <= '0;
      dob_q <= '0;
    end else begin
      doa_q <= mem[bus.addra];
      dob_q <= dob_d;
    end
  end

  assign bus.doa = doa_q;
  assign bus.dob = dob_q;

`ifdef SIM
  always @(posedge clk) begin
    if (resetb) begin
      if (bus.wea && $isunknown(bus.addra)) begin
        $display("%m(%t) X/Z on addra during write", $time);
      end
      if ($isunknown(bus.addrb)) begin
        $display("%m(%t) X/Z on addrb", $time);
      end
    end
  end
`endif

endmodule

// File: tb/tb_fifo_ram_sc.sv
// Directed bench for fifo_ram_sc: one instance per BYPASS setting, driven identically.
module tb_fifo_ram_sc;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 8;

  logic clk;
  logic resetb;
  int   n_vec;
  int   n_err;

  fifo_ram_sc_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus0 ();
  fifo_ram_sc_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus1 ();

  assign bus1.wea   = bus0.wea;
  assign bus1.addra = bus0.addra;
  assign bus1.dia   = bus0.dia;
  assign bus1.addrb = bus0.addrb;

  fifo_ram_sc #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYPASS(1'b0)) u_dut0 (
    .clk    (clk),
    .resetb (resetb),
    .bus    (bus0)
  );

  fifo_ram_sc #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYPASS(1'b1)) u_dut1 (
    .clk    (clk),
    .resetb (resetb),
    .bus    (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [DW-1:0] exp_b;
    n_vec       = 0;
    n_err       = 0;
    resetb      = 1'b0;
    bus0.wea    = 1'b0;
    bus0.addra  = '0;
    bus0.dia    = '0;
    bus0.addrb  = '0;

    step();
    step();
    chk("reset_doa0", bus0.doa, 8'h00);
    chk("reset_dob0", bus0.dob, 8'h00);
    chk("reset_dob1", bus1.dob, 8'h00);
    resetb = 1'b1;

    // Fill 0x10+i at address i.
    for (int i = 0; i < 16; i++) begin
      bus0.wea   = 1'b1;
      bus0.addra = AW'(i);
      bus0.dia   = DW'(8'h10 + i);
      step();
    end
    bus0.wea = 1'b0;

    for (int i = 0; i < 16; i++) begin
      bus0.addrb = AW'(i);
      step();
      chk($sformatf("sweep0_%0d", i), bus0.dob, DW'(8'h10 + i));
      chk($sformatf("sweep1_%0d", i), bus1.dob, DW'(8'h10 + i));
    end

    // addra is still 15 with wea low, so doa shows mem[15].
    chk("pre_reset_doa", bus0.doa, 8'h1F);
    #2;
    resetb = 1'b0;
    #1;
    chk("async_reset_doa", bus0.doa, 8'h00);
    chk("async_reset_dob", bus0.dob, 8'h00);
    bus0.wea   = 1'b1;
    bus0.addra = 4'd0;
    bus0.dia   = 8'hEE;
    step();
    chk("in_reset_doa", bus0.doa, 8'h00);
    chk("in_reset_dob", bus1.dob, 8'h00);
    resetb   = 1'b1;
    bus0.wea = 1'b0;
    step();
    chk("write_ignored_in_reset", bus0.doa, 8'h10);

    // Read-first on port A.
    bus0.wea   = 1'b1;
    bus0.addra = 4'd3;
    bus0.dia   = 8'hAA;
    step();
    bus0.dia = 8'h55;
    step();
    chk("read_first_old", bus0.doa, 8'hAA);
    bus0.wea = 1'b0;
    step();
    chk("read_first_new", bus0.doa, 8'h55);

    // Collision at address 7.
    bus0.wea   = 1'b1;
    bus0.addra = 4'd7;
    bus0.dia   = 8'h11;
    bus0.addrb = 4'd0;
    step();
    bus0.addrb = 4'd7;
    bus0.dia   = 8'h22;
    step();
    chk("collide_dob_bypass0", bus0.dob, 8'h11);
    chk("collide_dob_bypass1", bus1.dob, 8'h22);
    chk("collide_doa0", bus0.doa, 8'h11);
    chk("collide_doa1", bus1.doa, 8'h11);
    bus0.wea = 1'b0;
    step();
    chk("post_collide_dob0", bus0.dob, 8'h22);
    chk("post_collide_dob1", bus1.dob, 8'h22);

    // Stream with the read pointer two behind the write pointer, across the wrap.
    for (int i = 0; i < 20; i++) begin
      bus0.wea   = 1'b1;
      bus0.addra = AW'(i % 16);
      bus0.dia   = DW'(8'h80 + i);
      bus0.addrb = AW'((i + 14) % 16);
      step();
      if (i < 2) exp_b = DW'(8'h1E + i);
      else       exp_b = DW'(8'h80 + i - 2);
      chk($sformatf("stream0_%0d", i), bus0.dob, exp_b);
      chk($sformatf("stream1_%0d", i), bus1.dob, exp_b);
    end
    bus0.wea = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
